// File: rtl/fp16_pkg.sv
// Shared binary16 format constants, types and unpack helpers for the FP adder front end.
package fp16_pkg;

    localparam int EXP_W     = 5;
    localparam int FRAC_W    = 10;
    localparam int MAN_W     = 16;
    localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;
    localparam int SHIFT_SAT = 14;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

    typedef logic [MAN_W-1:0] man_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        man_t             man_l;
        man_t             man_s;
        logic [EXP_W-1:0] d;
        logic             eff_sub;
        logic             special;
        logic             nan;
    } align_s1_t;

    // Word layout {2'b00, hidden, frac, G, R, S}
    function automatic man_t unpack_man(input fp16_t x);
        return {2'b00, (x.exp != '0), x.frac, 3'b000};
    endfunction

    function automatic logic [EXP_W-1:0] eff_exp(input fp16_t x);
        return (x.exp == '0) ? 5'd1 : x.exp;
    endfunction

endpackage

// File: rtl/fp16_rshift_sticky.sv
// Combinational significand right shifter with saturation; the sticky bit is
// collected only when FP16_ALIGN_STICKY_EN is defined, otherwise it is tied to 0.
module fp16_rshift_sticky
    import fp16_pkg::*;
(
    input  man_t             din,
    input  logic [EXP_W-1:0] d,
    output man_t             dout
);

    localparam logic [EXP_W-1:0] SAT = EXP_W'(SHIFT_SAT);

    man_t shifted;
    man_t lost_mask;
    logic s;

    always_comb begin
        shifted   = din >> d;
        lost_mask = ~(man_t'('1) << d);
`ifdef FP16_ALIGN_STICKY_EN
        // The S slot absorbs whatever lands in it plus everything pushed past it
        s = (|(din & lost_mask)) | shifted[0];
`else
        s = 1'b0;
`endif
        dout = '0;
        if (d >= SAT) begin
            dout[0] = s;
        end else begin
            dout = {shifted[MAN_W-1:1], s};
        end
    end

endmodule

// File: rtl/fp16_align.sv
// Two-stage valid/ready operand alignment front end for the binary16 adder.
// Build option: FP16_ALIGN_STICKY_EN enables sticky collection in the shifter.
module fp16_align
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic        out_ci,
    output logic [4:0]  out_exp,
    output logic        out_sign,
    output logic        out_special,
    output logic        out_nan
);

    fp16_t     a, b, lg, sm;
    align_s1_t s1, s1_nx;
    logic      s1_valid;
    logic      s1_en, s2_en;
    logic      sb_eff, swap, sg_l, sg_s;
    logic      nan_a, nan_b, inf_a, inf_b;
    man_t      aligned;

    assign a = in_a;
    assign b = in_b;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    always_comb begin
        sb_eff = b.sign ^ in_sub;
        // Ties keep A as the larger operand
        swap   = {b.exp, b.frac} > {a.exp, a.frac};
        lg     = swap ? b : a;
        sm     = swap ? a : b;
        sg_l   = swap ? sb_eff : a.sign;
        sg_s   = swap ? a.sign : sb_eff;
        nan_a  = (a.exp == EXP_MAX) && (a.frac != '0);
        nan_b  = (b.exp == EXP_MAX) && (b.frac != '0);
        inf_a  = (a.exp == EXP_MAX) && (a.frac == '0);
        inf_b  = (b.exp == EXP_MAX) && (b.frac == '0);

        s1_nx         = '0;
        s1_nx.sign    = sg_l;
        s1_nx.exp     = eff_exp(lg);
        s1_nx.man_l   = unpack_man(lg);
        s1_nx.man_s   = unpack_man(sm);
        s1_nx.d       = eff_exp(lg) - eff_exp(sm);
        s1_nx.eff_sub = sg_l ^ sg_s;
        s1_nx.special = (a.exp == EXP_MAX) || (b.exp == EXP_MAX);
        s1_nx.nan     = nan_a || nan_b || (inf_a && inf_b && (sg_l ^ sg_s));
    end

    fp16_rshift_sticky u_shift (
        .din  (s1.man_s),
        .d    (s1.d),
        .dout (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1          <= '0;
            out_valid   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_ci      <= 1'b0;
            out_exp     <= '0;
            out_sign    <= 1'b0;
            out_special <= 1'b0;
            out_nan     <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1 <= s1_nx;
                end
            end
            if (s2_en) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_a       <= s1.man_l;
                    out_b       <= s1.eff_sub ? ~aligned : aligned;
                    out_ci      <= s1.eff_sub;
                    out_exp     <= s1.exp;
                    out_sign    <= s1.sign;
                    out_special <= s1.special;
                    out_nan     <= s1.nan;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp16_align.sv
// Scoreboard bench for fp16_align: directed cases with fixed expectations plus
// randomized operands checked against an arithmetic reference model.
module tb_fp16_align;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_a, out_b;
    logic        out_ci;
    logic [4:0]  out_exp;
    logic        out_sign, out_special, out_nan;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [4:0]  e;
        logic        sg;
        logic        sp;
        logic        nan;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   accepts = 0;
    int   rdy_mode = 0;

    fp16_align dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_sub      (in_sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_ci      (out_ci),
        .out_exp     (out_exp),
        .out_sign    (out_sign),
        .out_special (out_special),
        .out_nan     (out_nan)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom % 4) != 0;
        endcase
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Reference: value-level description of the alignment, using integer arithmetic
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        exp_t r;
        int unsigned ea, eb, fa, fb, el, es, fl, fs, ml, ms, d, q, rem, al, sbit;
        bit sa, sbe, sl, ss, effsub, nana, nanb, infa, infb;
        ea = a[14:10]; fa = a[9:0]; sa = a[15];
        eb = b[14:10]; fb = b[9:0]; sbe = b[15] ^ sub;
        if (eb * 1024 + fb > ea * 1024 + fa) begin
            el = eb; fl = fb; sl = sbe; es = ea; fs = fa; ss = sa;
        end else begin
            el = ea; fl = fa; sl = sa; es = eb; fs = fb; ss = sbe;
        end
        ml = ((el != 0) ? 8192 : 0) + fl * 8;
        ms = ((es != 0) ? 8192 : 0) + fs * 8;
        if (el == 0) el = 1;
        if (es == 0) es = 1;
        d = el - es;
        if (d >= 14) begin
`ifdef FP16_ALIGN_STICKY_EN
            al = (ms != 0) ? 1 : 0;
`else
            al = 0;
`endif
        end else begin
            q   = ms / (1 << d);
            rem = ms % (1 << d);
`ifdef FP16_ALIGN_STICKY_EN
            sbit = ((q % 2) != 0 || rem != 0) ? 1 : 0;
`else
            sbit = 0;
`endif
            al = q - (q % 2) + sbit;
        end
        effsub = (sl != ss);
        nana = (ea == 31) && (fa != 0);
        nanb = (eb == 31) && (fb != 0);
        infa = (ea == 31) && (fa == 0);
        infb = (eb == 31) && (fb == 0);
        r.a   = 16'(ml);
        r.b   = effsub ? 16'(65535 - al) : 16'(al);
        r.ci  = effsub;
        r.e   = 5'(el);
        r.sg  = sl;
        r.sp  = (ea == 31) || (eb == 31);
        r.nan = nana || nanb || (infa && infb && effsub);
        return r;
    endfunction

    function automatic exp_t mk(input logic [15:0] a, input logic [15:0] b, input logic ci,
                                input logic [4:0] e, input logic sg, input logic sp, input logic nan);
        exp_t r;
        r.a = a; r.b = b; r.ci = ci; r.e = e; r.sg = sg; r.sp = sp; r.nan = nan;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got a=%h b=%h expected no transfer", out_a, out_b);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("special", out_special, e.sp);
                check("nan", out_nan, e.nan);
                if (!e.sp) begin
                    check("out_a", out_a, e.a);
                    check("out_b", out_b, e.b);
                    check("out_ci", out_ci, e.ci);
                    check("out_exp", out_exp, e.e);
                    check("out_sign", out_sign, e.sg);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sub, input exp_t e);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_sub = sub;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                accepts++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        tests++;
        fails++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [15:0] a, b;
        logic        s;
        a = 16'($urandom);
        b = 16'($urandom);
        s = 1'($urandom);
        case ($urandom % 4)
            0: b[14:10] = a[14:10] ^ 5'($urandom % 4);
            1: b = a;
            2: b[14:10] = 5'd0;
            default: ;
        endcase
        send(a, b, s, model(a, b, s));
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_flags", {out_ci, out_sign, out_special, out_nan}, 0);
        check("rst_out_exp", out_exp, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk);
        #1;

        // Directed cases with hand-derived expectations
        send(16'h3C00, 16'h3C00, 1'b0, mk(16'h2000, 16'h2000, 1'b0, 5'd15, 1'b0, 1'b0, 1'b0));
        send(16'h3C00, 16'h3800, 1'b0, mk(16'h2000, 16'h1000, 1'b0, 5'd15, 1'b0, 1'b0, 1'b0));
        send(16'h3800, 16'hBC00, 1'b0, mk(16'h2000, 16'hEFFF, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0));
        send(16'h3C00, 16'h3C00, 1'b1, mk(16'h2000, 16'hDFFF, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0));
`ifdef FP16_ALIGN_STICKY_EN
        send(16'h3C00, 16'h0001, 1'b0, mk(16'h2000, 16'h0001, 1'b0, 5'd15, 1'b0, 1'b0, 1'b0));
`else
        send(16'h3C00, 16'h0001, 1'b0, mk(16'h2000, 16'h0000, 1'b0, 5'd15, 1'b0, 1'b0, 1'b0));
`endif
        send(16'h7C00, 16'h7C00, 1'b1, mk(16'h0, 16'h0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b1));
        send(16'h7E00, 16'h3C00, 1'b0, mk(16'h0, 16'h0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b1));
        send(16'h7C00, 16'h7C00, 1'b0, mk(16'h0, 16'h0, 1'b0, 5'd31, 1'b0, 1'b1, 1'b0));
        drain();

        // Backpressure: two entries fill the pipe, then in_ready must drop
        rdy_mode = 1;
        accepts = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) send_rand();
            end
        join_none
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_accepts", 16'(accepts), 16'd2);
        check("bp_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        for (int i = 0; i < 100 && accepts < 5; i++) begin
            @(posedge clk);
        end
        #1;
        check("bp_all_accepted", 16'(accepts), 16'd5);
        drain();

        // Random traffic with random output stalls and input gaps
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            send_rand();
            if ($urandom % 4 == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // Reset mid-stream discards in-flight entries
        for (int n = 0; n < 6; n++) send_rand();
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 40; n++) send_rand();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp16_align.md
# fp16_align

Operand-alignment front end of the half-precision floating-point adder. It unpacks two IEEE-754 binary16 operands, orders them by magnitude, and right-shifts the smaller significand with guard/round/sticky. It drives the 16-bit carry-lookahead adder with two aligned 16-bit words and a carry-in, pre-complementing for effective subtraction. It is a 2-stage valid/ready pipeline.

## Interface
- No parameters. Formats are fixed by the shared package.
- `clk  in  1` — single clock, rising edge.
- `rst  in  1` — synchronous, active-high reset.
- `in_valid  in  1` — operand pair present.
- `in_ready  out  1` — stage 1 can accept this cycle.
- `in_a  in  16` — binary16 operand A.
- `in_b  in  16` — binary16 operand B.
- `in_sub  in  1` — 1 computes A−B, 0 computes A+B.
- `out_valid  out  1` — aligned result present.
- `out_ready  in  1` — adder stage accepts.
- `out_a  out  16` — larger-magnitude significand, feeds adder `a`.
- `out_b  out  16` — aligned smaller significand, complemented when `out_ci`=1; feeds adder `b`.
- `out_ci  out  1` — effective-subtract flag, feeds adder `ci`.
- `out_exp  out  5` — effective exponent of the larger operand.
- `out_sign  out  1` — sign of the larger operand, i.e. the result sign.
- `out_special  out  1` — either operand has exp=31.
- `out_nan  out  1` — result is NaN: either operand is NaN, or inf−inf under effective subtraction.

## Operation
- **Significand word layout** `{2'b00, hidden, frac[9:0], G, R, S}`:
  - hidden at bit 13; bits 15:14 are headroom.
- **Unpack:**
  - exp=0 → hidden=0 and effective exp=1 (subnormal).
  - Otherwise hidden=1 and effective exp = exp.
- **Stage 1** (register on accept):
  - Effective sign of B = `in_b[15]^in_sub`.
  - Compare {exp,frac} of A and B. If B's is strictly greater, swap the operands; ties keep A as larger.
  - `eff_sub` = larger sign XOR effective sign of smaller.
  - `d` = expL − expS, 5 bits.
  - Latch special/NaN flags.
- **Stage 2** (register on advance):
  - If d≥14, aligned = 0 except sticky.
  - Otherwise aligned = smaller word >> d. S = S_in OR any bit shifted out.
  - `out_b` = eff_sub ? ~aligned : aligned. `out_ci` = eff_sub.
  - `out_a` = larger word, unshifted.
- Specials are passed with flags; significand outputs are don't-care when `out_special`=1. Downstream stages own special-case results.

## Timing
- **Reset:** all state clears.
  - `out_valid`=0 and both internal valids=0.
  - All data outputs = 0.
  - `in_ready`=1 in the first cycle after reset deasserts.
- **Latency:** 2 cycles from accept (`in_valid&in_ready`) to `out_valid`. Throughput is 1 per cycle.
- **Advance enables:**
  - `s2_en = !out_valid | out_ready`
  - `s1_en = !s1_valid | s2_en`
  - `in_ready = s1_en` (combinational from `out_ready`).
- **Output hold:** `out_*` are registered. They hold stable while `out_valid & !out_ready`.
- **Full:** both stages are full and `out_ready`=0 → `in_ready`=0; no data is lost or duplicated.
- **Simultaneous events:** simultaneous output drain and input accept is legal and keeps full throughput.
- **Reset mid-operation:** synchronous reset discards both in-flight entries. No output transfer occurs in the reset cycle.

## Configuration
- **`FP16_ALIGN_STICKY_EN` defined:** S = OR of all shifted-out bits, as in Operation.
- **Undefined:** shifted-out bits are dropped (truncation) and S is always 0. A d≥14 shift then yields aligned=0.

## Structure
- **Package `fp16_pkg`:**
  - Constants `EXP_W=5`, `FRAC_W=10`, `MAN_W=16`, `EXP_MAX=5'd31`, `SHIFT_SAT=14`.
  - Typedef `fp16_t` (sign/exp/frac struct).
  - Typedef `man_t` (16-bit significand word).
  - Stage-1 register struct `align_s1_t`.
- **Sub-module `fp16_rshift_sticky`:** combinational 16-bit right shifter with sticky OR-reduce and saturation at `SHIFT_SAT`. Its sticky logic is gated by the macro.

## Test plan
- 0x3C00 + 0x3C00, sub=0 → two cycles later: `out_a`=0x2000, `out_b`=0x2000, `out_ci`=0, `out_exp`=15, `out_sign`=0.
- 0x3C00 + 0x3800 → `out_a`=0x2000, `out_b`=0x1000, `out_ci`=0, `out_exp`=15.
- 0x3800 + 0xBC00 → operands swap: `out_a`=0x2000, `out_b`=~0x1000=0xEFFF, `out_ci`=1, `out_sign`=1.
- 0x3C00 + 0x0001 → d=14:
  - With macro: `out_b`=0x0001.
  - Without macro: `out_b`=0x0000.
- Special operands:
  - 0x7C00 − 0x7C00 → `out_special`=1, `out_nan`=1.
  - 0x7E00 + 0x3C00 → `out_nan`=1.
- Backpressure:
  - Stream 5 pairs with `out_ready`=0 for 4 cycles → `in_ready` falls after 2 accepts. All 5 emerge in order, unchanged.
  - Assert `rst` mid-stream → `out_valid`=0 on the next cycle.
